// File: rtl/nn_datapath_pkg.sv
// nn_datapath shared constants, opcodes and field helpers.
// Imported by the datapath and its weight memory.
package nn_datapath_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int RESULT_WIDTH = 32;
  localparam int DP_OP_WIDTH = 4;
  localparam int DP_ADDR_FIELD = 12;
  localparam int DP_DATA_FIELD = 16;
  localparam logic [RESULT_WIDTH-1:0] DP_ERROR = 32'hFFFF_FFFF;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [DP_OP_WIDTH-1:0] {
    DP_OP_NOP    = 4'd0,
    DP_OP_READ   = 4'd1,
    DP_OP_WRITE  = 4'd2,
    DP_OP_MAC    = 4'd3,
    DP_OP_CLRACC = 4'd4,
    DP_OP_MUTATE = 4'd5,
    DP_OP_RAND   = 4'd6,
    DP_OP_RESEED = 4'd7
  } dp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC
  } dp_state_e;

  function automatic logic [DP_OP_WIDTH-1:0] op_of(
    input logic [INSTRUCTION_WIDTH-1:0] i
  );
    return i[31:28];
  endfunction

  function automatic logic [DP_ADDR_FIELD-1:0] addr_of(
    input logic [INSTRUCTION_WIDTH-1:0] i
  );
    return i[27:16];
  endfunction

  function automatic logic [DP_DATA_FIELD-1:0] data_of(
    input logic [INSTRUCTION_WIDTH-1:0] i
  );
    return i[15:0];
  endfunction

  // Ops that need the weight read issued a cycle ahead.
  function automatic logic is_mem(input logic [DP_OP_WIDTH-1:0] op);
    return (op == DP_OP_READ) || (op == DP_OP_MAC) ||
           (op == DP_OP_MUTATE);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0);
  endfunction

  function automatic logic [31:0] sat32(input logic [32:0] v);
    if (v[32] != v[31])
      return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return v[31:0];
  endfunction

endpackage

// File: rtl/nn_datapath_weight_ram.sv
// Genome weight store: single port, registered read,
// written on the clock edge when we is high.
module nn_datapath_weight_ram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int WEIGHT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic [WEIGHT_WIDTH-1:0] rd_data
);

  logic [WEIGHT_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we)
      mem[addr] <= wr_data;
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/nn_datapath.sv
// Single-issue execution datapath: weight RAM, MAC
// accumulator and Galois LFSR behind a start/finished handshake.
import nn_datapath_pkg::*;

module nn_datapath #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          WEIGHT_WIDTH = 16,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result
);

  localparam int W = WEIGHT_WIDTH;

  dp_state_e             state;
  logic                  start_q;
  logic                  accept;
  logic [3:0]            ir_op;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [15:0]           ir_data;
  logic [31:0]           acc;
  logic [15:0]           lfsr;

  logic                  we;
  logic [W-1:0]          rd_data;
  logic [W-1:0]          wr_data;

  logic signed [31:0]    w_s;
  logic signed [31:0]    d_s;
  logic signed [31:0]    prod;
  logic signed [31:0]    prod_sh;
  logic [32:0]           mac_sum;
  logic [31:0]           mac_sat;
  logic signed [15:0]    delta;
  logic [W:0]            mut_sum;
  logic [W-1:0]          mut_w;
  logic [31:0]           mut_ext;
  logic [15:0]           seed_new;

  assign accept = start & ~start_q & (state == ST_IDLE);

  assign w_s     = {{(32-W){rd_data[W-1]}}, rd_data};
  assign d_s     = {{16{ir_data[15]}}, ir_data};
  assign prod    = w_s * d_s;
  assign prod_sh = prod >>> 8;
  assign mac_sum = {acc[31], acc} + {prod_sh[31], prod_sh};
  assign mac_sat = sat32(mac_sum);

  // LFSR is read as a signed Q8.8 delta for mutation.
  assign delta   = $signed(lfsr) >>> ir_data[3:0];
  assign mut_sum = {rd_data[W-1], rd_data} +
                   {{(W-15){delta[15]}}, delta};
  assign mut_w   = (mut_sum[W] != mut_sum[W-1]) ?
                   {mut_sum[W], {(W-1){~mut_sum[W]}}} :
                   mut_sum[W-1:0];
  assign mut_ext = {{(32-W){mut_w[W-1]}}, mut_w};

  assign seed_new = (ir_data == 16'h0) ? SEED : ir_data;

  assign we = (state == ST_EXEC) & ~reset &
              ((ir_op == DP_OP_WRITE) | (ir_op == DP_OP_MUTATE));
  assign wr_data = (ir_op == DP_OP_MUTATE) ? mut_w :
                   W'($signed(ir_data));

  nn_datapath_weight_ram #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WEIGHT_WIDTH(W)
  ) u_ram (
    .clock  (clock),
    .we     (we),
    .addr   (ir_addr),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      ir_op    <= 4'h0;
      ir_addr  <= '0;
      ir_data  <= 16'h0;
      acc      <= 32'h0;
      lfsr     <= SEED;
      finished <= 1'b1;
      result   <= 32'h0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ir_op    <= op_of(instruction);
            ir_addr  <= ADDR_WIDTH'(addr_of(instruction));
            ir_data  <= data_of(instruction);
            finished <= 1'b0;
            state    <= is_mem(op_of(instruction)) ?
                        ST_FETCH : ST_EXEC;
          end
        end
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          state    <= ST_IDLE;
          finished <= 1'b1;
          case (ir_op)
            DP_OP_NOP:    result <= 32'h0;
            DP_OP_READ:   result <= w_s;
            DP_OP_WRITE:  result <= d_s;
            DP_OP_MAC: begin
              acc    <= mac_sat;
              result <= mac_sat;
            end
            DP_OP_CLRACC: begin
              acc    <= 32'h0;
              result <= 32'h0;
            end
            DP_OP_MUTATE: begin
              result <= mut_ext;
              lfsr   <= lfsr_next(lfsr);
            end
            DP_OP_RAND: begin
              result <= {16'h0, lfsr};
              lfsr   <= lfsr_next(lfsr);
            end
            DP_OP_RESEED: begin
              lfsr   <= seed_new;
              result <= {16'h0, seed_new};
            end
            default: result <= DP_ERROR;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_datapath.sv
// Randomized bench for nn_datapath against an arithmetic
// reference model, plus fixed directed expectations.
module tb_nn_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic        finished;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  bit          chk_en = 1'b0;
  logic        exp_fin;
  logic [31:0] exp_res;

  logic [15:0] m_mem [1024];
  longint      m_acc;
  logic [15:0] m_lfsr;

  always #5 clock = ~clock;

  nn_datapath dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .instruction(instruction),
    .finished   (finished),
    .result     (result)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("finished", {31'b0, finished}, {31'b0, exp_fin});
      chk("result", result, exp_res);
    end
  end

  function automatic bit mem_op(input logic [3:0] op);
    return op == 4'd1 || op == 4'd3 || op == 4'd5;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0);
  endfunction

  task automatic model(input logic [3:0] op, input logic [11:0] a,
                       input logic [15:0] d, output logic [31:0] r);
    int     ai;
    longint p;
    longint s;
    int     w;
    int     dl;
    int     ms;
    ai = int'(a) % 1024;
    case (op)
      4'd0: r = 32'h0;
      4'd1: r = 32'(int'($signed(m_mem[ai])));
      4'd2: begin
        m_mem[ai] = d;
        r = 32'(int'($signed(d)));
      end
      4'd3: begin
        p = longint'($signed(m_mem[ai])) * longint'($signed(d));
        s = m_acc + (p >>> 8);
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        m_acc = s;
        r = 32'(m_acc);
      end
      4'd4: begin
        m_acc = 0;
        r = 32'h0;
      end
      4'd5: begin
        w  = int'($signed(m_mem[ai]));
        dl = int'($signed(m_lfsr)) >>> d[3:0];
        ms = w + dl;
        if (ms > 32767) ms = 32767;
        if (ms < -32768) ms = -32768;
        m_mem[ai] = 16'(ms);
        r = 32'(ms);
        m_lfsr = lfsr_step(m_lfsr);
      end
      4'd6: begin
        r = {16'h0, m_lfsr};
        m_lfsr = lfsr_step(m_lfsr);
      end
      4'd7: begin
        m_lfsr = (d == 16'h0) ? 16'hACE1 : d;
        r = {16'h0, m_lfsr};
      end
      default: r = 32'hFFFF_FFFF;
    endcase
  endtask

  task automatic run(input logic [3:0] op, input logic [11:0] a,
                     input logic [15:0] d, input int hold,
                     input bit glitch);
    int lat;
    int n;
    logic [31:0] r;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    instruction = {op, a, d};
    lat = mem_op(op) ? 2 : 1;
    n = (hold > lat) ? hold : lat;
    @(posedge clock);
    #1;
    exp_fin = 1'b0;
    if (glitch) start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (glitch && c == 1) begin
        @(negedge clock);
        start = 1'b1;
      end
      @(posedge clock);
      #1;
      if (c == lat) begin
        model(op, a, d, r);
        exp_fin = 1'b1;
        exp_res = r;
      end
      if (c >= hold && !glitch) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic reset_mid(input logic [3:0] op, input logic [11:0] a,
                           input logic [15:0] d);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    instruction = {op, a, d};
    @(posedge clock);
    #1;
    exp_fin = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clock);
    #1;
    exp_fin = 1'b1;
    exp_res = 32'h0;
    m_acc = 0;
    m_lfsr = 16'hACE1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [3:0]  op;
    logic [11:0] a;
    logic [15:0] d;
    reset = 1'b1;
    start = 1'b0;
    instruction = 32'h0;
    m_acc = 0;
    m_lfsr = 16'hACE1;
    exp_fin = 1'b1;
    exp_res = 32'h0;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_finished", {31'b0, finished}, 32'h1);
    chk("rst_result", result, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      run(4'd2, 12'(i), 16'($urandom), 1, 1'b0);

    run(4'd2, 12'd5, 16'h0180, 1, 1'b0);
    run(4'd1, 12'd5, 16'h0, 1, 1'b0);
    chk("read5", result, 32'h0000_0180);
    run(4'd1, 12'h405, 16'h0, 1, 1'b0);
    chk("read5_wrap", result, 32'h0000_0180);

    run(4'd4, 12'd0, 16'h0, 1, 1'b0);
    run(4'd2, 12'd1, 16'h0200, 1, 1'b0);
    run(4'd3, 12'd1, 16'h0300, 1, 1'b0);
    chk("mac_pos", result, 32'h0000_0600);
    run(4'd3, 12'd1, 16'h8000, 1, 1'b0);
    chk("mac_neg", result, 32'hFFFF_0600);

    run(4'd2, 12'd2, 16'h7F00, 1, 1'b0);
    run(4'd7, 12'd0, 16'h7FFF, 1, 1'b0);
    run(4'd5, 12'd2, 16'h0000, 1, 1'b0);
    chk("mut_sat_hi", result, 32'h0000_7FFF);
    run(4'd1, 12'd2, 16'h0, 1, 1'b0);
    chk("mut_rd_hi", result, 32'h0000_7FFF);
    run(4'd2, 12'd3, 16'h8100, 1, 1'b0);
    run(4'd7, 12'd0, 16'h8000, 1, 1'b0);
    run(4'd5, 12'd3, 16'h0000, 1, 1'b0);
    chk("mut_sat_lo", result, 32'hFFFF_8000);

    run(4'd7, 12'd0, 16'h0001, 1, 1'b0);
    run(4'd6, 12'd0, 16'h0, 1, 1'b0);
    chk("rand1", result, 32'h0000_0001);
    run(4'd6, 12'd0, 16'h0, 1, 1'b0);
    chk("rand2", result, 32'h0000_B400);
    run(4'd7, 12'd0, 16'h0000, 1, 1'b0);
    chk("reseed0", result, 32'h0000_ACE1);

    run(4'hF, 12'd1, 16'h1234, 4, 1'b0);
    chk("illegal", result, 32'hFFFF_FFFF);
    run(4'd3, 12'd1, 16'h0000, 1, 1'b0);
    run(4'd3, 12'd1, 16'h0100, 4, 1'b1);
    run(4'd6, 12'd0, 16'h0, 1, 1'b0);

    reset_mid(4'd3, 12'd1, 16'h0300);
    run(4'd1, 12'd5, 16'h0, 1, 1'b0);
    chk("rst_read", result, 32'h0000_0180);
    run(4'd3, 12'd1, 16'h0100, 1, 1'b0);
    chk("rst_mac", result, 32'h0000_0200);
    reset_mid(4'd5, 12'd2, 16'h0000);
    run(4'd1, 12'd2, 16'h0, 1, 1'b0);
    chk("rst_nowrite", result, 32'h0000_7FFF);

    run(4'd2, 12'd4, 16'h8000, 1, 1'b0);
    for (int i = 0; i < 520; i++)
      run(4'd3, 12'd4, 16'h8000, 1, 1'b0);
    chk("mac_sat32", result, 32'h7FFF_FFFF);
    run(4'd4, 12'd0, 16'h0, 1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 12'($urandom_range(0, 15)) |
           (12'($urandom_range(0, 3)) << 10);
      d  = 16'($urandom);
      run(op, a, d, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
